// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the value producer/encoder side and the seven-segment scan controller.
interface seg7_scan_ctrl_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic        lzb;
    logic [3:0]  dp_in;
    logic [3:0]  nib;
    logic [6:0]  seg_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output value, load, digit_en, lzb, dp_in, seg_in,
        input  nib, an, seg, dp, frame_tick
    );

    modport slave (
        input  value, load, digit_en, lzb, dp_in, seg_in,
        output nib, an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// The display value is latched into the shadow register only on frame boundaries, so a frame never mixes two values.
module seg7_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      pending;
    logic [15:0]      shadow;
    logic             started;

    logic slot_end_c;
    logic frame_end_c;
    logic lead_zero_c;
    logic blank_c;

    always_comb begin
        slot_end_c  = (cnt == CNT_MAX);
        frame_end_c = slot_end_c && (idx == 2'd3);
    end

    // Digit idx is a leading zero when it and every higher nibble are zero; digit 0 never qualifies.
    always_comb begin
        lead_zero_c = 1'b0;
        case (idx)
            2'd1:    lead_zero_c = (shadow[15:4]  == 12'h000);
            2'd2:    lead_zero_c = (shadow[15:8]  == 8'h00);
            2'd3:    lead_zero_c = (shadow[15:12] == 4'h0);
            default: lead_zero_c = 1'b0;
        endcase
    end

    always_comb begin
        blank_c = (32'(cnt) < BLANK_CYCLES)
               || !bus.digit_en[idx]
               || (bus.lzb && lead_zero_c);
    end

    assign bus.nib = 4'(shadow >> {idx, 2'b00});

    // Scan counters and value capture; a load in the boundary cycle itself goes straight to shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= 2'd0;
            pending <= 16'h0000;
            shadow  <= 16'h0000;
            started <= 1'b0;
        end else begin
            cnt <= slot_end_c ? '0 : cnt + CNT_W'(1);
            if (slot_end_c) begin
                idx <= idx + 2'd1;
            end
            if (bus.load) begin
                pending <= bus.value;
            end
            if (frame_end_c) begin
                shadow  <= bus.load ? bus.value : pending;
                started <= 1'b1;
            end
        end
    end

    // Pin register: everything shown after an edge reflects the scan state held before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an         <= 4'b1111;
            bus.seg        <= 7'b111_1111;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= blank_c ? 4'b1111 : ~(4'b0001 << idx);
            bus.seg        <= blank_c ? 7'b111_1111 : bus.seg_in;
            bus.dp         <= blank_c ? 1'b1 : ~bus.dp_in[idx];
            bus.frame_tick <= started && (cnt == '0) && (idx == 2'd0);
        end
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the 4-digit common-anode seven-segment display. It holds a 16-bit display value, steps one shared hex-to-seven-segment encoder through the four nibbles, and drives the active-low anodes so each digit is lit in turn. The block sits between the lab datapath (value producer) and the board display pins. Value updates take effect only on frame boundaries, so a frame never mixes digits from two values.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 1000: anti-ghosting blank at the start of each slot; legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- value  in  16  display value; nibble k drives digit k, and digit 0 is the rightmost.
- load  in  1  single-cycle strobe that captures value into the pending register.
- digit_en  in  4  per-digit enable; 0 keeps that anode off for its whole slot.
- lzb  in  1  leading-zero blanking enable.
- dp_in  in  4  decimal point request per digit; 1 = lit.
- nib  out  4  nibble sent to the external hex encoder; combinational from idx and shadow.
- seg_in  in  7  encoder result for nib; active-low, bit 6 = segment a … bit 0 = segment g.
- an  out  4  anodes, active-low, registered.
- seg  out  7  segments, active-low, registered; same bit order as seg_in.
- dp  out  1  decimal point, active-low, registered.
- frame_tick  out  1  one-cycle pulse at frame start, registered.

## Operation
- State:
  - cnt: width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1.
  - idx: 2 bits.
  - pending: 16 bits.
  - shadow: 16 bits.
- Slot advance: when cnt reaches REFRESH_DIV-1, cnt wraps to 0 and idx increments. idx wraps from 3 to 0; that 3→0 transition is the frame boundary.
- Load capture: load=1 sets pending ← value. A later load overwrites pending; the last one before the boundary wins.
- Shadow transfer: at the frame boundary, shadow ← pending.
  - If load=1 in the boundary cycle itself, shadow ← value directly, and pending ← value.
- Encoder drive: nib = shadow[4*idx +: 4].
- Digit blanking: the digit is blank when any of these holds:
  - cnt < BLANK_CYCLES;
  - digit_en[idx] = 0;
  - lzb = 1, idx ≥ 1, and shadow nibbles idx..3 are all zero. Digit 0 is never zero-suppressed.
- Output register, updated every cycle:
  - an ← blank ? 4'b1111 : ~(1 << idx)
  - seg ← blank ? 7'b1111111 : seg_in
  - dp ← blank ? 1 : ~dp_in[idx]
- Disabled or suppressed digits still consume their full slot, so brightness stays uniform.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - Outputs: an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0, so nib = 0.
  - Internal: cnt = 0, idx = 0, pending = 0, shadow = 0.
- Latency: outputs lag cnt/idx by exactly one clock. The output value after edge k reflects the state held before edge k.
- Slot and frame length: each slot is REFRESH_DIV cycles; each frame is 4·REFRESH_DIV cycles. The anode is low for REFRESH_DIV − BLANK_CYCLES cycles per enabled slot.
- frame_tick: high for exactly one cycle, coincident with the first output cycle of the idx=0 slot of each new frame. It is not asserted on the first frame after reset.
- Value latency: a load becomes visible at the start of the next frame. At most one frame plus one cycle elapses from load to the first affected output.
- Reset mid-operation: outputs blank immediately, and state returns to the reset values.
- seg_in is sampled every cycle. The external encoder must be purely combinational, with nib → seg_in settling within one clock.

## Test plan
Bench settings for all scenarios: REFRESH_DIV = 8, BLANK_CYCLES = 2, with the encoder instantiated combinationally.

1. Reset release → an = 1111 and seg = 1111111 for 2 edges; an = 1110 and seg = 0000001 (digit "0") from the 3rd edge through the 8th edge; then 2 blank cycles; then an = 1101.
2. load 16'h12AF, digit_en = 1111, lzb = 0; wait one frame → slots show, in order:
   - an = 1110 with seg = 0111000 (F)
   - an = 1101 with seg = 0001000 (A)
   - an = 1011 with seg = 0010010 (2)
   - an = 0111 with seg = 1001111 (1)
   Each digit is lit for 6 cycles; frame_tick pulses every 32 cycles.
3. lzb = 1, value 16'h0005 → anodes 1..3 never go low, and digit 0 shows seg = 0100100. Then value 16'h0000 → digit 0 shows 0000001, and digits 1..3 stay dark.
4. shadow = 16'h2222; load 16'h1111 during the idx=1 slot → the idx=2 and idx=3 slots still show 0010010. From the frame_tick onward, all digits show 1001111.
5. digit_en = 0101, dp_in = 0001 → only an = 1110 and an = 1011 ever appear. dp = 0 only while an = 1110.
6. Drop rst_n during the idx=2 lit phase, asynchronously between edges → an = 1111, seg = 1111111, dp = 1 within the same cycle. After release, digit 0 shows "0", because shadow was cleared.
